// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types.
//   word_t         32-bit datapath word
//   RV32I_NOP      canonical NOP (addi x0, x0, 0)
//   fetch_state_t  fetch FSM: FETCH issues reads, DISCARD drains a wrong-path read
//   fetch_ex_t     contents of the IF/EX pipeline latch
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RV32I_NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t pc4;
    logic  misaligned;
  } fetch_ex_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   imem_addr   read address            (master -> slave)
//   imem_ren    read enable             (master -> slave)
//   imem_rdata  read data, valid when !imem_busy (slave -> master)
//   imem_busy   read not yet complete   (slave -> master)
interface fetch_stage_if;
  import rv32i_types_pkg::*;

  word_t imem_addr;
  logic  imem_ren;
  word_t imem_rdata;
  logic  imem_busy;

  modport master (
    output imem_addr,
    output imem_ren,
    input  imem_rdata,
    input  imem_busy
  );

  modport slave (
    input  imem_addr,
    input  imem_ren,
    output imem_rdata,
    output imem_busy
  );

endinterface

// File: rtl/fetch_ex_latch.sv
// IF/EX pipeline register. Priority: flush > stall > load.
//   i_clk    clock
//   i_nrst   synchronous active-low reset
//   i_flush  invalidate entry (valid=0, instr=NOP, misaligned=0; pc/pc4 hold)
//   i_stall  hold all fields
//   i_d      next entry when neither flush nor stall
//   o_q      current latch contents
module fetch_ex_latch
  import rv32i_types_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_nrst,
  input  logic      i_flush,
  input  logic      i_stall,
  input  fetch_ex_t i_d,
  output fetch_ex_t o_q
);

  fetch_ex_t r_q;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_q.valid      <= 1'b0;
      r_q.instr      <= RV32I_NOP;
      r_q.pc         <= '0;
      r_q.pc4        <= '0;
      r_q.misaligned <= 1'b0;
    end else if (i_flush) begin
      r_q.valid      <= 1'b0;
      r_q.instr      <= RV32I_NOP;
      r_q.misaligned <= 1'b0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, instruction-memory address mux, and a
// two-state FSM that drains a read made wrong-path by a redirect.
//   CLK, nRST            clock, synchronous active-low reset
//   pc_en, npc_sel       hazard unit: advance PC / select brj_addr over PC+4
//   if_ex_stall/flush    hazard unit: hold / invalidate IF/EX latch
//   brj_addr             redirect target from execute
//   i_ram_busy, iren     to hazard unit: fetch incomplete / stage active
//   imem                 instruction-memory bus (master side)
//   fetch_ex_*           IF/EX latch outputs
module fetch_stage
  import rv32i_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0200
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          pc_en,
  input  logic          npc_sel,
  input  logic          if_ex_stall,
  input  logic          if_ex_flush,
  input  word_t         brj_addr,
  output logic          i_ram_busy,
  output logic          iren,
  fetch_stage_if.master imem,
  output logic          fetch_ex_valid,
  output word_t         fetch_ex_instr,
  output word_t         fetch_ex_pc,
  output word_t         fetch_ex_pc4,
  output logic          fetch_ex_misaligned
);

  word_t        r_pc;
  word_t        r_hold_addr;
  fetch_state_t r_state;
  logic         r_active;

  logic      w_aligned;
  logic      w_ren;
  logic      w_done;
  word_t     w_pc4;
  fetch_ex_t w_latch_d;
  fetch_ex_t w_latch_q;

  always_comb begin
    w_aligned = (r_pc[1:0] == 2'b00);
    w_pc4     = r_pc + 32'd4;
    w_ren     = r_active & ((r_state == DISCARD) | w_aligned);
    // Misaligned PCs complete at once without touching memory.
    w_done    = r_active & (r_state == FETCH) & (!w_aligned | !imem.imem_busy);

    imem.imem_addr = (r_state == DISCARD) ? r_hold_addr : r_pc;
    imem.imem_ren  = w_ren;
    i_ram_busy     = r_active & !w_done;
    iren           = r_active;

    w_latch_d.valid      = w_done;
    w_latch_d.instr      = w_aligned ? imem.imem_rdata : RV32I_NOP;
    w_latch_d.pc         = r_pc;
    w_latch_d.pc4        = w_pc4;
    w_latch_d.misaligned = !w_aligned;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_pc        <= RESET_PC;
      r_hold_addr <= '0;
      r_state     <= FETCH;
      r_active    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (pc_en) begin
        r_pc <= npc_sel ? brj_addr : w_pc4;
      end
      case (r_state)
        FETCH: begin
          // Redirect while a read is outstanding: remember its address and
          // keep presenting it until memory completes, then drop the data.
          if (pc_en && npc_sel && imem.imem_busy && w_ren) begin
            r_hold_addr <= r_pc;
            r_state     <= DISCARD;
          end
        end
        DISCARD: begin
          if (!imem.imem_busy) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  fetch_ex_latch u_latch (
    .i_clk   (CLK),
    .i_nrst  (nRST),
    .i_flush (if_ex_flush),
    .i_stall (if_ex_stall),
    .i_d     (w_latch_d),
    .o_q     (w_latch_q)
  );

  assign fetch_ex_valid      = w_latch_q.valid;
  assign fetch_ex_instr      = w_latch_q.instr;
  assign fetch_ex_pc         = w_latch_q.pc;
  assign fetch_ex_pc4        = w_latch_q.pc4;
  assign fetch_ex_misaligned = w_latch_q.misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import rv32i_types_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam word_t BAD = 32'hBAD0_BAD0;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  pc_en, npc_sel, if_ex_stall, if_ex_flush;
  word_t brj_addr;
  logic  i_ram_busy, iren;
  logic  fetch_ex_valid, fetch_ex_misaligned;
  word_t fetch_ex_instr, fetch_ex_pc, fetch_ex_pc4;
  logic  busy_in;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0200)) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .pc_en               (pc_en),
    .npc_sel             (npc_sel),
    .if_ex_stall         (if_ex_stall),
    .if_ex_flush         (if_ex_flush),
    .brj_addr            (brj_addr),
    .i_ram_busy          (i_ram_busy),
    .iren                (iren),
    .imem                (bus.master),
    .fetch_ex_valid      (fetch_ex_valid),
    .fetch_ex_instr      (fetch_ex_instr),
    .fetch_ex_pc         (fetch_ex_pc),
    .fetch_ex_pc4        (fetch_ex_pc4),
    .fetch_ex_misaligned (fetch_ex_misaligned)
  );

  always #5 CLK = ~CLK;

  // Memory model: distinct word per address; garbage while busy.
  function automatic word_t mem(input word_t a);
    return {~a[31:16], a[15:0]};
  endfunction

  assign bus.imem_busy  = busy_in;
  assign bus.imem_rdata = busy_in ? BAD : mem(bus.imem_addr);

  typedef struct {
    logic  pc_en, npc_sel;
    word_t brj;
    logic  busy, stall, flush;
    word_t e_addr;
    logic  e_ren, e_rbusy;
  } row_t;

  typedef struct {
    logic  valid;
    word_t instr, pc, pc4;
    logic  mis;
    logic  known;
  } exp_t;

  exp_t held;
  exp_t sb[$];

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " iren"},       {31'd0, iren}, 32'd0);
    chk({tag, " imem_ren"},   {31'd0, bus.imem_ren}, 32'd0);
    chk({tag, " i_ram_busy"}, {31'd0, i_ram_busy}, 32'd0);
    chk({tag, " valid"},      {31'd0, fetch_ex_valid}, 32'd0);
    chk({tag, " instr"},      fetch_ex_instr, RV32I_NOP);
    chk({tag, " pc"},         fetch_ex_pc, 32'd0);
    chk({tag, " pc4"},        fetch_ex_pc4, 32'd0);
    chk({tag, " misaligned"}, {31'd0, fetch_ex_misaligned}, 32'd0);
    chk({tag, " imem_addr"},  bus.imem_addr, 32'h0000_0200);
  endtask

  task automatic run_row(input int idx, input row_t r);
    exp_t e;
    logic done;
    @(negedge CLK);
    pc_en = r.pc_en; npc_sel = r.npc_sel; brj_addr = r.brj;
    busy_in = r.busy; if_ex_stall = r.stall; if_ex_flush = r.flush;
    #1;
    chk($sformatf("row%0d imem_addr", idx), bus.imem_addr, r.e_addr);
    chk($sformatf("row%0d imem_ren", idx), {31'd0, bus.imem_ren}, {31'd0, r.e_ren});
    chk($sformatf("row%0d i_ram_busy", idx), {31'd0, i_ram_busy}, {31'd0, r.e_rbusy});
    chk($sformatf("row%0d iren", idx), {31'd0, iren}, 32'd1);
    done = !r.e_rbusy;
    if (done && !r.flush && !r.stall) begin
      e.valid = 1'b1;
      e.mis   = (r.e_addr[1:0] != 2'b00);
      e.instr = e.mis ? RV32I_NOP : mem(r.e_addr);
      e.pc    = r.e_addr;
      e.pc4   = r.e_addr + 32'd4;
      e.known = 1'b1;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    if (r.flush) begin
      held.valid = 1'b0; held.instr = RV32I_NOP; held.mis = 1'b0; held.known = 1'b1;
    end else if (!r.stall) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL row%0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
          held = sb.pop_front();
        end
      end else begin
        held.valid = 1'b0; held.known = 1'b0;
      end
    end
    chk($sformatf("row%0d valid", idx), {31'd0, fetch_ex_valid}, {31'd0, held.valid});
    if (held.known) begin
      chk($sformatf("row%0d instr", idx), fetch_ex_instr, held.instr);
      chk($sformatf("row%0d misaligned", idx), {31'd0, fetch_ex_misaligned}, {31'd0, held.mis});
    end
    if (held.valid) begin
      chk($sformatf("row%0d pc", idx), fetch_ex_pc, held.pc);
      chk($sformatf("row%0d pc4", idx), fetch_ex_pc4, held.pc4);
    end
  endtask

  row_t tbl[20];

  initial begin
    //          pc_en npc  brj             busy stall flush e_addr          ren rbusy
    tbl[0]  = '{H, L, 32'h0,           L, L, L, 32'h0000_0200, H, L}; // 0x200
    tbl[1]  = '{L, L, 32'h0,           H, L, L, 32'h0000_0204, H, H}; // 3 wait states
    tbl[2]  = '{L, L, 32'h0,           H, L, L, 32'h0000_0204, H, H};
    tbl[3]  = '{L, L, 32'h0,           H, L, L, 32'h0000_0204, H, H};
    tbl[4]  = '{H, L, 32'h0,           L, L, L, 32'h0000_0204, H, L}; // 0x204 done
    tbl[5]  = '{H, H, 32'h0000_0400,   H, L, L, 32'h0000_0208, H, H}; // redirect while busy
    tbl[6]  = '{L, L, 32'h0,           H, L, L, 32'h0000_0208, H, H}; // DISCARD
    tbl[7]  = '{L, L, 32'h0,           L, L, L, 32'h0000_0208, H, H}; // drained, dropped
    tbl[8]  = '{H, L, 32'h0,           L, L, L, 32'h0000_0400, H, L}; // target
    tbl[9]  = '{L, L, 32'h0,           L, H, L, 32'h0000_0404, H, L}; // stall holds
    tbl[10] = '{L, L, 32'h0,           L, H, L, 32'h0000_0404, H, L};
    tbl[11] = '{L, L, 32'h0,           L, H, H, 32'h0000_0404, H, L}; // flush beats stall
    tbl[12] = '{H, H, 32'h0000_0402,   L, L, L, 32'h0000_0404, H, L}; // idle redirect
    tbl[13] = '{H, H, 32'hFFFF_FFFC,   H, L, L, 32'h0000_0402, L, L}; // misaligned, busy ignored
    tbl[14] = '{H, L, 32'h0,           L, L, L, 32'hFFFF_FFFC, H, L}; // pc4 wraps
    tbl[15] = '{H, L, 32'h0,           L, L, L, 32'h0000_0000, H, L}; // pc wrapped
    tbl[16] = '{H, H, 32'h0000_0800,   H, L, L, 32'h0000_0004, H, H}; // redirect while busy
    tbl[17] = '{H, H, 32'h0000_0900,   H, L, L, 32'h0000_0004, H, H}; // second redirect in DISCARD
    tbl[18] = '{L, L, 32'h0,           L, L, L, 32'h0000_0004, H, H}; // drained
    tbl[19] = '{H, L, 32'h0,           L, L, L, 32'h0000_0900, H, L}; // latest target wins

    held = '{valid: 1'b0, instr: RV32I_NOP, pc: '0, pc4: '0, mis: 1'b0, known: 1'b1};
    nRST = 1'b0; pc_en = 1'b0; npc_sel = 1'b0; brj_addr = '0;
    if_ex_stall = 1'b0; if_ex_flush = 1'b0; busy_in = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");

    // Release reset with pc_en low so 0x200 is the first address fetched.
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("release iren", {31'd0, iren}, 32'd1);
    chk("release imem_addr", bus.imem_addr, 32'h0000_0200);

    for (int unsigned i = 0; i < 20; i++) run_row(int'(i), tbl[i]);

    // Reset arriving mid-DISCARD abandons the read.
    run_row(20, '{H, H, 32'h0000_0A00, H, L, L, 32'h0000_0904, H, H});
    @(negedge CLK);
    nRST = 1'b0; pc_en = 1'b0; npc_sel = 1'b0; busy_in = 1'b1;
    #1;
    chk("pre-reset discard addr", bus.imem_addr, 32'h0000_0904);
    @(posedge CLK);
    #1;
    chk_reset_outputs("discard-reset");

    // Back in FETCH after release: address is RESET_PC, not the stale hold address.
    @(negedge CLK);
    nRST = 1'b1; busy_in = 1'b0;
    @(posedge CLK);
    #1;
    chk("post-reset imem_addr", bus.imem_addr, 32'h0000_0200);
    chk("post-reset imem_ren", {31'd0, bus.imem_ren}, 32'd1);
    chk("post-reset i_ram_busy", {31'd0, i_ram_busy}, 32'd0);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
